usb_uart_streamer: RTL and testbench
====================================

# usb_uart_streamer

Downstream consumer of the status annunciator's byte stream. It pulls one byte at a time over the `inc`/`dout`/`dout_v` handshake, serialises each byte as 8N1 UART on a single TX pin, and then requests the next byte. This gives the debug status screen a continuous refresh over a serial link. It runs in the 48 MHz USB clock domain.

## Interface
Parameters:
- `CLK_HZ`, default 48000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `REQ_TIMEOUT`, default 4: number of cycles to wait for `din_v` after a request before re-requesting.

Ports:
- `clk48`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: streaming enable. Sampled only in IDLE and at the end of a stop bit.
- `inc`, out, 1: byte request strobe to the upstream source.
- `din`, in, 8: byte from upstream (annunciator `dout`).
- `din_v`, in, 1: byte-valid pulse from upstream (annunciator `dout_v`).
- `tx`, out, 1: UART line. Idles high.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- `CPB = (CLK_HZ + BAUD/2) / BAUD`, rounded to the nearest integer; 417 at the defaults. The bit counter is wide enough for `CPB-1`.
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE: `tx` = 1. If `enable` is high, go to REQ.
- REQ: assert `inc` for exactly this one cycle, clear the timeout counter, then go to WAIT.
- WAIT: `inc` = 0.
  - If `din_v` is high, latch `din` into the shift register and go to START.
  - Otherwise increment the timeout counter. When it reaches `REQ_TIMEOUT`, return to REQ. This covers the upstream wrap cycle, which consumes an `inc` without producing `din_v`.
- START: `tx` = 0 for CPB cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift register bit 0 (LSB first) for CPB cycles per bit. Shift right after each bit. After bit 7, go to STOP.
- STOP: `tx` = 1 for CPB cycles. Then go to REQ if `enable` is high, otherwise IDLE.
- `din_v` is ignored in every state except WAIT. This includes the spurious `dout_v` = 1 that upstream presents out of its own reset.
- `enable` falling mid-frame: the current frame completes, and the block enters IDLE after the stop bit.
- Reset values: state IDLE, `tx` = 1, `inc` = 0, `busy` = 0, counters 0, shift register 0.
- Reset mid-frame: `tx` is high on the cycle after `rst` is sampled. The truncated byte is not resent.

## Timing
- All outputs are registered.
- `inc` is high for one cycle and is always low for at least REQ_TIMEOUT cycles between consecutive requests. This satisfies upstream's requirement that `inc` drop before the next byte is issued.
- Upstream returns `din_v` one cycle after sampling `inc`. In WAIT, `din_v` may arrive on any cycle from the first WAIT cycle up to the timeout.
- `din_v` captured in cycle N: `tx` falls in cycle N+1.
- Frame length: exactly 10·CPB cycles from the start-bit falling edge to the end of the stop bit.
- `inc` for the next byte: the cycle after the stop bit ends.
- Steady-state byte period: 10·CPB + 3 cycles (REQ, one WAIT cycle, capture).
- `din_v` coincident with the timeout terminal count: the capture wins and no re-request is issued.

## Structure
- Shared package `usb_debug_pkg`:
  - default `CLK_HZ`/`BAUD` constants;
  - the state enum `uart_state_t`;
  - a function computing CPB with rounding.
- One sub-module, `uart_baud_tick`. It is a CPB-cycle down-counter that emits `tick` on its terminal count and reloads on `restart`. The FSM restarts it on entry to START.
- Top-level RTL: FSM, shift register, bit index, and timeout counter.

## Test plan
- Reset release with `enable` = 1 and upstream `din_v` held high:
  - `tx` stays 1 until the first REQ;
  - the stale `din_v` is ignored;
  - `inc` pulses once on cycle 1.
- Send byte 0x41: `tx` shows start 0, then bits 1,0,0,0,0,0,1,0, then stop 1, each held exactly 417 cycles. The next `inc` occurs 4170 cycles after the start edge.
- No `din_v` after `inc` (upstream wrap): `inc` re-pulses after exactly REQ_TIMEOUT + 1 cycles, and `tx` stays high throughout.
- `enable` dropped during DATA bit 3: the frame completes intact, the block enters IDLE, and no further `inc` is issued. Re-raising `enable` gives an `inc` on the following cycle.
- `rst` asserted during DATA: `tx` = 1 and `busy` = 0 on the next cycle. After release, the first `inc` restarts cleanly.
- Back-to-back stream of "0123" from a behavioural upstream model: four contiguous frames with correct bytes and a byte period of 4173 cycles.

Source files
------------

// File: rtl/usb_debug_pkg.sv
// Shared definitions for the USB-domain debug streaming blocks.
// Holds the default clock/baud rates, the UART FSM state type and the bit-period helper.
package usb_debug_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 48_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  // Clocks per UART bit, rounded to nearest so the baud error stays symmetric.
  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/usb_uart_streamer_if.sv
// Byte-pull handshake between the status annunciator (master, byte source) and the UART streamer (slave).
interface usb_uart_streamer_if;

  logic       inc;
  logic [7:0] din;
  logic       din_v;

  modport master (output din, output din_v, input inc);
  modport slave  (input din, input din_v, output inc);

endinterface

// File: rtl/usb_uart_streamer_baud_tick.sv
// Bit-period timer: counts CPB cycles down and pulses tick on the terminal count.
// restart reloads the full period so the first bit after it lasts exactly CPB cycles.
module uart_baud_tick #(
  parameter int unsigned CPB = 417
) (
  input  logic clk48,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CPB > 1) ? $clog2(CPB) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk48) begin
    if (rst) begin
      count <= '0;
    end else if (restart || (count == '0)) begin
      count <= CW'(CPB - 1);
    end else begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0) && !restart;

endmodule

// File: rtl/usb_uart_streamer.sv
// Pulls bytes from the annunciator over inc/din/din_v and sends each one as 8N1 UART on tx.
// Requests are re-issued after REQ_TIMEOUT idle cycles to ride over the upstream wrap cycle.
module usb_uart_streamer
  import usb_debug_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD        = DEFAULT_BAUD,
  parameter int unsigned REQ_TIMEOUT = 4
) (
  input  logic                clk48,
  input  logic                rst,
  input  logic                enable,
  usb_uart_streamer_if.slave  up,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned CPB = calc_cpb(CLK_HZ, BAUD);
  localparam int unsigned TW  = $clog2(REQ_TIMEOUT + 1);

  uart_state_t   state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [TW-1:0] tcount;
  logic          inc_q;
  logic          baud_restart;
  logic          baud_tick;

  assign up.inc = inc_q;

  // The timer is reloaded on the same edge that enters START, so the start bit is a full period.
  assign baud_restart = (state == ST_WAIT) && up.din_v;

  uart_baud_tick #(
    .CPB(CPB)
  ) u_baud (
    .clk48  (clk48),
    .rst    (rst),
    .restart(baud_restart),
    .tick   (baud_tick)
  );

  always_ff @(posedge clk48) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      inc_q   <= 1'b0;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      tcount  <= '0;
    end else begin
      inc_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (enable) begin
            state <= ST_REQ;
            inc_q <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          tcount <= '0;
          state  <= ST_WAIT;
        end
        // A byte arriving on the terminal-count cycle is still taken; no re-request then.
        ST_WAIT: begin
          if (up.din_v) begin
            shreg <= up.din;
            tx    <= 1'b0;
            state <= ST_START;
          end else if (tcount == TW'(REQ_TIMEOUT - 1)) begin
            state <= ST_REQ;
            inc_q <= 1'b1;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (enable) begin
              state <= ST_REQ;
              inc_q <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_uart_streamer.sv
// Directed bench for usb_uart_streamer at the default 48 MHz / 115200 baud (417 clocks per bit).
// A registered upstream model answers each inc with din_v two cycles later while it has bytes queued.
module tb_usb_uart_streamer;

  localparam int CPB = 417;

  logic clk48 = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic tx;
  logic busy;

  logic       force_v = 1'b0;
  logic [7:0] force_d = 8'h00;
  logic       model_v = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] model_d = 8'h00;
  logic [7:0] d_pend = 8'h00;
  logic [7:0] byte_q[$];

  int asserts = 0;
  int fails = 0;
  int cyc = 0;

  usb_uart_streamer_if u_if ();

  assign u_if.din_v = force_v | model_v;
  assign u_if.din   = model_v ? model_d : force_d;

  usb_uart_streamer #(
    .CLK_HZ     (48000000),
    .BAUD       (115200),
    .REQ_TIMEOUT(4)
  ) dut (
    .clk48 (clk48),
    .rst   (rst),
    .enable(enable),
    .up    (u_if.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk48 = ~clk48;

  // Upstream samples inc, then presents the byte with din_v one registered cycle later.
  always @(posedge clk48) begin
    if (u_if.inc === 1'b1 && byte_q.size() > 0) begin
      d1     <= 1'b1;
      d_pend <= byte_q.pop_front();
    end else begin
      d1 <= 1'b0;
    end
    model_v <= d1;
    model_d <= d_pend;
  end

  task automatic step();
    @(negedge clk48);
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_inc(input int limit, output int n, output logic tx_all_high);
    n = 0;
    tx_all_high = 1'b1;
    do begin
      step();
      n++;
      tx_all_high &= tx;
    end while (u_if.inc !== 1'b1 && n < limit);
  endtask

  task automatic wait_tx_low(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tx !== 1'b0 && n < limit);
  endtask

  // Entered on the first start-bit cycle; leaves on the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int drop_at, input string tag);
    logic [9:0] bits;
    int bad;
    int inc_seen;
    bits = {1'b1, b, 1'b0};
    inc_seen = 0;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (k * CPB + j == drop_at) enable = 1'b0;
        if (tx !== bits[k]) bad++;
        if (u_if.inc !== 1'b0) inc_seen++;
        if (!(k == 9 && j == CPB - 1)) step();
      end
      check_output($sformatf("%s bit%0d wrong cycles", tag, k), bad, 0);
    end
    check_output($sformatf("%s inc during frame", tag), inc_seen, 0);
  endtask

  initial begin
    int n;
    int start;
    int prev_start;
    int incs;
    logic txh;
    logic [7:0] stream[4];
    stream[0] = 8'h30;
    stream[1] = 8'h31;
    stream[2] = 8'h32;
    stream[3] = 8'h33;

    // Reset with enable high and a stale din_v from upstream's own reset.
    rst = 1'b1;
    enable = 1'b1;
    force_v = 1'b1;
    force_d = 8'hEE;
    repeat (3) step();
    check_output("reset tx", tx, 1);
    check_output("reset inc", u_if.inc, 0);
    check_output("reset busy", busy, 0);

    rst = 1'b0;
    step();
    check_output("first inc", u_if.inc, 1);
    check_output("first inc tx", tx, 1);
    check_output("first inc busy", busy, 1);
    force_v = 1'b0;

    // Nothing queued: the request times out and repeats after REQ_TIMEOUT+1 cycles.
    wait_inc(20, n, txh);
    check_output("wrap re-inc spacing", n, 5);
    check_output("wrap tx high", txh, 1);

    byte_q.push_back(8'h41);
    wait_tx_low(20, n);
    check_output("0x41 start latency", n, 3);
    start = cyc;
    check_frame(8'h41, -1, "0x41");
    step();
    check_output("0x41 next inc", u_if.inc, 1);
    check_output("0x41 inc offset", cyc - start, 10 * CPB);

    // Enable drops during data bit 3; the frame still finishes, then the block idles.
    byte_q.push_back(8'h5A);
    wait_tx_low(20, n);
    check_output("0x5A start latency", n, 3);
    check_frame(8'h5A, 4 * CPB + 100, "0x5A");
    step();
    check_output("idle inc", u_if.inc, 0);
    check_output("idle busy", busy, 0);
    check_output("idle tx", tx, 1);
    incs = 0;
    repeat (30) begin
      step();
      if (u_if.inc !== 1'b0) incs++;
    end
    check_output("idle no inc", incs, 0);
    enable = 1'b1;
    step();
    check_output("re-enable inc", u_if.inc, 1);

    // Reset lands mid-frame while a 0 data bit is on the line.
    byte_q.push_back(8'h33);
    wait_tx_low(20, n);
    check_output("0x33 start latency", n, 3);
    repeat (3 * CPB + 200) step();
    check_output("pre-reset tx", tx, 0);
    check_output("pre-reset busy", busy, 1);
    rst = 1'b1;
    step();
    check_output("mid reset tx", tx, 1);
    check_output("mid reset busy", busy, 0);
    check_output("mid reset inc", u_if.inc, 0);
    rst = 1'b0;
    step();
    check_output("post reset inc", u_if.inc, 1);

    // Back-to-back "0123" stream.
    for (int i = 0; i < 4; i++) byte_q.push_back(stream[i]);
    prev_start = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tx_low(20, n);
      check_output($sformatf("stream%0d start latency", i), n, 3);
      if (i > 0) check_output($sformatf("stream%0d period", i), cyc - prev_start, 10 * CPB + 3);
      prev_start = cyc;
      check_frame(stream[i], -1, $sformatf("stream%0d", i));
      step();
      check_output($sformatf("stream%0d next inc", i), u_if.inc, 1);
    end

    enable = 1'b0;
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
